// File: rtl/vga_pkg.sv
// Shared VGA definitions: active-area constants, coordinate types and the
// state encoding used by the bouncing character box controller.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    typedef logic [9:0]  coord_t;
    typedef logic [10:0] calc_t;

    localparam logic DIR_POS = 1'b0;
    localparam logic DIR_NEG = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_CALC,
        ST_COMMIT
    } bounce_state_t;

    // Colour sequence skips 0 so the box never turns black
    function automatic logic [3:0] next_color(input logic [3:0] color);
        if (color == 4'd15 || color == 4'd0)
            return 4'd1;
        else
            return color + 4'd1;
    endfunction

endpackage

// File: rtl/char_axis_step.sv
// One-axis position stepper: advances pos by step toward 0 or max_pos,
// clamping and reversing direction when an edge is reached.
module char_axis_step
    import vga_pkg::*;
(
    input  coord_t pos,
    input  logic   dir,
    input  calc_t  step,
    input  calc_t  max_pos,
    output coord_t next_pos,
    output logic   next_dir,
    output logic   hit
);

    calc_t pos_w;
    calc_t sum;

    assign pos_w = {1'b0, pos};
    assign sum   = pos_w + step;

    always_comb begin
        next_pos = pos;
        next_dir = dir;
        hit      = 1'b0;
        if (dir == DIR_POS) begin
            if (sum >= max_pos) begin
                next_pos = coord_t'(max_pos);
                next_dir = DIR_NEG;
                hit      = 1'b1;
            end else begin
                next_pos = coord_t'(sum);
            end
        end else begin
            if (pos_w <= step) begin
                next_pos = '0;
                next_dir = DIR_POS;
                hit      = 1'b1;
            end else begin
                next_pos = coord_t'(pos_w - step);
            end
        end
    end

endmodule

// File: rtl/char_bounce_ctrl.sv
// Bouncing character box controller: moves the box once per video frame and
// reports edge hits. Define CHAR_BOUNCE_COLOR_EN to step the colour on bounce.
module char_bounce_ctrl #(
    parameter int         H_ACTIVE   = vga_pkg::H_ACTIVE,
    parameter int         V_ACTIVE   = vga_pkg::V_ACTIVE,
    parameter int         CHAR_W     = 64,
    parameter int         CHAR_H     = 32,
    parameter int         STEP       = 4,
    parameter logic [3:0] INIT_COLOR = 4'h1
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       en,
    input  logic       freeze,
    input  logic       vsync,
    input  logic       load_vld,
    input  logic [9:0] load_x,
    input  logic [9:0] load_y,
    output logic [9:0] char_x_start,
    output logic [9:0] char_x_end,
    output logic [9:0] char_y_start,
    output logic [9:0] char_y_end,
    output logic [3:0] char_color,
    output logic       bounce
);

    import vga_pkg::*;

    localparam calc_t  XMAX   = calc_t'(H_ACTIVE - CHAR_W);
    localparam calc_t  YMAX   = calc_t'(V_ACTIVE - CHAR_H);
    localparam calc_t  STEP_C = calc_t'(STEP);
    localparam coord_t X_SPAN = coord_t'(CHAR_W - 1);
    localparam coord_t Y_SPAN = coord_t'(CHAR_H - 1);

    bounce_state_t state;
    logic          vsync_q;
    logic          tick;

    coord_t x_pos, y_pos;
    logic   x_dir, y_dir;
    logic [3:0] color_q;

    coord_t pend_x, pend_y;
    logic   pend_x_dir, pend_y_dir;
    logic   pend_hit;

    coord_t x_next, y_next;
    logic   x_dir_next, y_dir_next;
    logic   x_hit, y_hit;

    coord_t load_x_clamped, load_y_clamped;

    assign tick = vsync_q & ~vsync;

    assign load_x_clamped = ({1'b0, load_x} > XMAX) ? coord_t'(XMAX) : load_x;
    assign load_y_clamped = ({1'b0, load_y} > YMAX) ? coord_t'(YMAX) : load_y;

    char_axis_step u_x_step (
        .pos      (x_pos),
        .dir      (x_dir),
        .step     (STEP_C),
        .max_pos  (XMAX),
        .next_pos (x_next),
        .next_dir (x_dir_next),
        .hit      (x_hit)
    );

    char_axis_step u_y_step (
        .pos      (y_pos),
        .dir      (y_dir),
        .step     (STEP_C),
        .max_pos  (YMAX),
        .next_pos (y_next),
        .next_dir (y_dir_next),
        .hit      (y_hit)
    );

    // Load has priority over the frame step; dropping en abandons any pending
    // update so the visible box never moves while the block is disabled.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= ST_IDLE;
            vsync_q    <= 1'b1;
            x_pos      <= '0;
            y_pos      <= '0;
            x_dir      <= DIR_POS;
            y_dir      <= DIR_POS;
            color_q    <= INIT_COLOR;
            bounce     <= 1'b0;
            pend_x     <= '0;
            pend_y     <= '0;
            pend_x_dir <= DIR_POS;
            pend_y_dir <= DIR_POS;
            pend_hit   <= 1'b0;
        end else begin
            vsync_q <= vsync;
            bounce  <= 1'b0;
            if (load_vld) begin
                x_pos <= load_x_clamped;
                y_pos <= load_y_clamped;
                state <= en ? ST_RUN : ST_IDLE;
            end else if (!en) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: state <= ST_RUN;
                    ST_RUN: begin
                        if (tick && !freeze)
                            state <= ST_CALC;
                    end
                    ST_CALC: begin
                        pend_x     <= x_next;
                        pend_y     <= y_next;
                        pend_x_dir <= x_dir_next;
                        pend_y_dir <= y_dir_next;
                        pend_hit   <= x_hit | y_hit;
                        state      <= ST_COMMIT;
                    end
                    ST_COMMIT: begin
                        x_pos  <= pend_x;
                        y_pos  <= pend_y;
                        x_dir  <= pend_x_dir;
                        y_dir  <= pend_y_dir;
                        bounce <= pend_hit;
`ifdef CHAR_BOUNCE_COLOR_EN
                        if (pend_hit)
                            color_q <= next_color(color_q);
`endif
                        state  <= ST_RUN;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign char_x_start = x_pos;
    assign char_y_start = y_pos;
    assign char_x_end   = x_pos + X_SPAN;
    assign char_y_end   = y_pos + Y_SPAN;
    assign char_color   = color_q;

endmodule

// File: tb/tb_char_bounce_ctrl.sv
// Self-checking bench for char_bounce_ctrl: table of load/tick vectors plus
// hand-written sequences for freeze, load/tick collision, en drop and reset.
module tb_char_bounce_ctrl;

    logic       sys_clk;
    logic       sys_rst;
    logic       en;
    logic       freeze;
    logic       vsync;
    logic       load_vld;
    logic [9:0] load_x;
    logic [9:0] load_y;
    logic [9:0] char_x_start;
    logic [9:0] char_x_end;
    logic [9:0] char_y_start;
    logic [9:0] char_y_end;
    logic [3:0] char_color;
    logic       bounce;

    int err_cnt = 0;
    int chk_cnt = 0;

    logic [9:0] cur_x;
    logic [9:0] cur_y;
    logic [3:0] exp_color;

    typedef struct {
        bit         is_load;
        logic [9:0] lx;
        logic [9:0] ly;
        logic [9:0] ex;
        logic [9:0] ey;
        logic       eb;
        logic [3:0] ec_on;
        string      name;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs[NV];

    char_bounce_ctrl dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .en           (en),
        .freeze       (freeze),
        .vsync        (vsync),
        .load_vld     (load_vld),
        .load_x       (load_x),
        .load_y       (load_y),
        .char_x_start (char_x_start),
        .char_x_end   (char_x_end),
        .char_y_start (char_y_start),
        .char_y_end   (char_y_end),
        .char_color   (char_color),
        .bounce       (bounce)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [3:0] bump_color(input logic [3:0] c);
`ifdef CHAR_BOUNCE_COLOR_EN
        return (c == 4'd15) ? 4'd1 : c + 4'd1;
`else
        return c;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [9:0] ex, input logic [9:0] ey,
                               input logic eb, input logic [3:0] ec);
        logic [9:0] exe;
        logic [9:0] eye;
        exe = ex + 10'd63;
        eye = ey + 10'd31;
        chk_cnt++;
        if ({char_x_start, char_x_end, char_y_start, char_y_end, bounce, char_color} !==
            {ex, exe, ey, eye, eb, ec}) begin
            err_cnt++;
            $display("[TB] FAIL %s: got x=%0d..%0d y=%0d..%0d bounce=%0b color=%0d, want x=%0d..%0d y=%0d..%0d bounce=%0b color=%0d",
                     name, char_x_start, char_x_end, char_y_start, char_y_end, bounce, char_color,
                     ex, exe, ey, eye, eb, ec);
        end
    endtask

    task automatic applyStimulus(input logic [9:0] lx, input logic [9:0] ly, input string name);
        @(negedge sys_clk);
        load_vld = 1'b1;
        load_x   = lx;
        load_y   = ly;
        @(posedge sys_clk);
        #1;
        cur_x = (lx > 10'd576) ? 10'd576 : lx;
        cur_y = (ly > 10'd448) ? 10'd448 : ly;
        checkOutput(name, cur_x, cur_y, 1'b0, exp_color);
        @(negedge sys_clk);
        load_vld = 1'b0;
    endtask

    // Frame tick: outputs must still be old one cycle later and new two cycles later
    task automatic doTick(input string name, input logic [9:0] ex, input logic [9:0] ey,
                          input logic eb, input logic [3:0] ec);
        @(negedge sys_clk);
        vsync = 1'b0;
        @(posedge sys_clk);
        @(negedge sys_clk);
        vsync = 1'b1;
        @(posedge sys_clk);
        #1;
        checkOutput({name, "_hold"}, cur_x, cur_y, 1'b0, exp_color);
        @(posedge sys_clk);
        #1;
        checkOutput(name, ex, ey, eb, ec);
        cur_x     = ex;
        cur_y     = ey;
        exp_color = ec;
        if (eb) begin
            @(posedge sys_clk);
            #1;
            checkOutput({name, "_pulse_end"}, cur_x, cur_y, 1'b0, exp_color);
        end
    endtask

    task automatic resetDut();
        @(negedge sys_clk);
        sys_rst = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1;
        cur_x     = 10'd0;
        cur_y     = 10'd0;
        exp_color = 4'd1;
        checkOutput("reset", 10'd0, 10'd0, 1'b0, 4'd1);
        @(negedge sys_clk);
        sys_rst = 1'b0;
    endtask

    initial begin
        logic       x_pos_dir;
        logic [9:0] lx;
        logic [3:0] ec;

        sys_rst  = 1'b0;
        en       = 1'b0;
        freeze   = 1'b0;
        vsync    = 1'b1;
        load_vld = 1'b0;
        load_x   = '0;
        load_y   = '0;

        vecs[0]  = '{1'b0, 10'd0,    10'd0,   10'd4,   10'd4,   1'b0, 4'd1, "first_tick"};
        vecs[1]  = '{1'b1, 10'd572,  10'd100, 10'd572, 10'd100, 1'b0, 4'd1, "load_572_100"};
        vecs[2]  = '{1'b0, 10'd0,    10'd0,   10'd576, 10'd104, 1'b1, 4'd2, "right_edge_hit"};
        vecs[3]  = '{1'b0, 10'd0,    10'd0,   10'd572, 10'd108, 1'b0, 4'd2, "moving_left"};
        vecs[4]  = '{1'b1, 10'd2,    10'd470, 10'd2,   10'd448, 1'b0, 4'd2, "load_clamp_y"};
        vecs[5]  = '{1'b0, 10'd0,    10'd0,   10'd0,   10'd448, 1'b1, 4'd3, "left_bottom_corner"};
        vecs[6]  = '{1'b0, 10'd0,    10'd0,   10'd4,   10'd444, 1'b0, 4'd3, "after_corner"};
        vecs[7]  = '{1'b1, 10'd1000, 10'd5,   10'd576, 10'd5,   1'b0, 4'd3, "load_clamp_x"};
        vecs[8]  = '{1'b0, 10'd0,    10'd0,   10'd576, 10'd1,   1'b1, 4'd4, "clamped_x_hit"};
        vecs[9]  = '{1'b0, 10'd0,    10'd0,   10'd572, 10'd0,   1'b1, 4'd5, "top_edge_hit"};
        vecs[10] = '{1'b0, 10'd0,    10'd0,   10'd568, 10'd4,   1'b0, 4'd5, "after_top"};

        resetDut();
        en = 1'b1;
        @(posedge sys_clk);

        for (int i = 0; i < NV; i++) begin
`ifdef CHAR_BOUNCE_COLOR_EN
            ec = vecs[i].ec_on;
`else
            ec = 4'd1;
`endif
            if (vecs[i].is_load)
                applyStimulus(vecs[i].lx, vecs[i].ly, vecs[i].name);
            else
                doTick(vecs[i].name, vecs[i].ex, vecs[i].ey, vecs[i].eb, ec);
        end

        // Corner hit with both directions positive gives a single pulse
        resetDut();
        applyStimulus(10'd576, 10'd448, "load_corner");
        doTick("corner_hit", 10'd576, 10'd448, 1'b1, bump_color(exp_color));
        doTick("corner_leave", 10'd572, 10'd444, 1'b0, exp_color);

        // Ticks while frozen are dropped, not queued
        @(negedge sys_clk);
        freeze = 1'b1;
        for (int i = 0; i < 3; i++)
            doTick("frozen", cur_x, cur_y, 1'b0, exp_color);
        @(negedge sys_clk);
        freeze = 1'b0;
        doTick("unfrozen_single_step", 10'd568, 10'd440, 1'b0, exp_color);

        // Load coincident with a tick: loaded value, no step
        @(negedge sys_clk);
        vsync    = 1'b0;
        load_vld = 1'b1;
        load_x   = 10'd300;
        load_y   = 10'd200;
        @(posedge sys_clk);
        #1;
        cur_x = 10'd300;
        cur_y = 10'd200;
        checkOutput("load_vs_tick", cur_x, cur_y, 1'b0, exp_color);
        @(negedge sys_clk);
        vsync    = 1'b1;
        load_vld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge sys_clk);
            #1;
            checkOutput("load_vs_tick_no_step", cur_x, cur_y, 1'b0, exp_color);
        end

        // Dropping en mid-update holds the outputs
        @(negedge sys_clk);
        vsync = 1'b0;
        @(posedge sys_clk);
        @(negedge sys_clk);
        vsync = 1'b1;
        en    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge sys_clk);
            #1;
            checkOutput("en_drop_hold", cur_x, cur_y, 1'b0, exp_color);
        end
        @(negedge sys_clk);
        en = 1'b1;
        @(posedge sys_clk);
        doTick("en_restored", 10'd296, 10'd196, 1'b0, exp_color);

        // Reset in CALC aborts a pending bounce
        applyStimulus(10'd2, 10'd100, "load_before_reset");
        @(negedge sys_clk);
        vsync = 1'b0;
        @(posedge sys_clk);
        @(negedge sys_clk);
        vsync   = 1'b1;
        sys_rst = 1'b1;
        @(posedge sys_clk);
        #1;
        cur_x     = 10'd0;
        cur_y     = 10'd0;
        exp_color = 4'd1;
        checkOutput("reset_in_calc", 10'd0, 10'd0, 1'b0, 4'd1);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge sys_clk);
            #1;
            checkOutput("reset_abort_no_update", 10'd0, 10'd0, 1'b0, 4'd1);
        end

        // Twenty bounces: colour wraps 15 -> 1, or stays fixed without the colour feature
        resetDut();
        x_pos_dir = 1'b1;
        for (int i = 0; i < 20; i++) begin
            lx = x_pos_dir ? 10'd576 : 10'd0;
            applyStimulus(lx, 10'd100, "bounce_loop_load");
            doTick("bounce_loop", lx, 10'd104, 1'b1, bump_color(exp_color));
            x_pos_dir = ~x_pos_dir;
        end
`ifdef CHAR_BOUNCE_COLOR_EN
        checkOutput("color_after_20", cur_x, 10'd104, 1'b0, 4'd6);
`else
        checkOutput("color_after_20", cur_x, 10'd104, 1'b0, 4'd1);
`endif

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
